// File: rtl/puf_challenge_sequencer.sv
// Ring-oscillator PUF initiator: LFSR challenge pairs, RO window gating, count compare, response handshake.
// Optional PUF_TIE_COUNT_EN adds tie_cnt. rst_n is asynchronous and active-high despite its name.
module puf_challenge_sequencer #(
  parameter int NBITS      = 8,
  parameter int CW         = 32,
  parameter int WINDOW     = 16,
  parameter int CLR_CYC    = 2,
  parameter int SETTLE_CYC = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [7:0]       seed,
  output logic [4:0]       sel_a,
  output logic [4:0]       sel_b,
  output logic             ro_ena,
  output logic             cnt_clr,
  input  logic [CW-1:0]    cnt_a,
  input  logic [CW-1:0]    cnt_b,
  output logic             busy,
  output logic [NBITS-1:0] resp_data,
  output logic             resp_valid,
  input  logic             resp_ready
`ifdef PUF_TIE_COUNT_EN
  ,
  output logic [7:0]       tie_cnt
`endif
);

  localparam int M1 = (WINDOW > CLR_CYC) ? WINDOW : CLR_CYC;
  localparam int M2 = (M1 > SETTLE_CYC) ? M1 : SETTLE_CYC;
  localparam int TW = $clog2(M2 + 1);
  localparam int IW = (NBITS > 1) ? $clog2(NBITS) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_RUN, S_SETTLE, S_COMPARE, S_NEXT, S_DONE
  } state_t;

  state_t        state;
  logic [9:0]    lfsr;
  logic [9:0]    lfsr_next;
  logic [TW-1:0] timer;
  logic [IW-1:0] bit_idx;

  // Returns {sel_b, sel_a}; bank B is nudged off bank A so a pair never compares an RO with itself.
  function automatic logic [9:0] sel_pair(input logic [9:0] l);
    logic [4:0] a;
    logic [4:0] b;
    a = l[4:0];
    b = l[9:5];
    if (b == a) b = b ^ 5'd1;
    return {b, a};
  endfunction

  always_comb begin
    lfsr_next = {lfsr[8:0], lfsr[9] ^ lfsr[6]};
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state      <= S_IDLE;
      lfsr       <= 10'h001;
      timer      <= '0;
      bit_idx    <= '0;
      sel_a      <= '0;
      sel_b      <= '0;
      ro_ena     <= 1'b0;
      cnt_clr    <= 1'b0;
      busy       <= 1'b0;
      resp_data  <= '0;
      resp_valid <= 1'b0;
`ifdef PUF_TIE_COUNT_EN
      tie_cnt    <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            lfsr           <= {seed, 2'b01};
            {sel_b, sel_a} <= sel_pair({seed, 2'b01});
            bit_idx        <= '0;
            resp_data      <= '0;
            timer          <= '0;
            cnt_clr        <= 1'b1;
            busy           <= 1'b1;
`ifdef PUF_TIE_COUNT_EN
            tie_cnt        <= '0;
`endif
            state          <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          if (timer == TW'(CLR_CYC - 1)) begin
            timer   <= '0;
            cnt_clr <= 1'b0;
            ro_ena  <= 1'b1;
            state   <= S_RUN;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        S_RUN: begin
          if (timer == TW'(WINDOW - 1)) begin
            timer  <= '0;
            ro_ena <= 1'b0;
            state  <= S_SETTLE;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        S_SETTLE: begin
          if (timer == TW'(SETTLE_CYC - 1)) begin
            timer <= '0;
            state <= S_COMPARE;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        S_COMPARE: begin
          resp_data[bit_idx] <= (cnt_a > cnt_b);
`ifdef PUF_TIE_COUNT_EN
          if ((cnt_a == cnt_b) && (tie_cnt != 8'hFF)) tie_cnt <= tie_cnt + 8'd1;
`endif
          state <= S_NEXT;
        end
        S_NEXT: begin
          if (bit_idx == IW'(NBITS - 1)) begin
            resp_valid <= 1'b1;
            state      <= S_DONE;
          end else begin
            bit_idx        <= bit_idx + IW'(1);
            lfsr           <= lfsr_next;
            {sel_b, sel_a} <= sel_pair(lfsr_next);
            cnt_clr        <= 1'b1;
            state          <= S_CLEAR;
          end
        end
        S_DONE: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            busy       <= 1'b0;
            state      <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
